// File: rtl/lsu_pkg.sv
// Shared types, I/O address offsets and lane helpers for the RV32I load-store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_op_e;

  typedef enum logic [2:0] {
    REG_DMEM = 3'd0,
    REG_LEDR = 3'd1,
    REG_LEDG = 3'd2,
    REG_HEX  = 3'd3,
    REG_SW   = 3'd4,
    REG_NONE = 3'd5
  } region_e;

  // Offsets from the I/O base address
  localparam logic [31:0] ADDR_LEDR = 32'h0000_0000;
  localparam logic [31:0] ADDR_LEDG = 32'h0000_1000;
  localparam logic [31:0] ADDR_HEX  = 32'h0000_2000;
  localparam logic [31:0] ADDR_SW   = 32'h0001_0000;

  function automatic logic [3:0] be_f(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      LSU_B, LSU_BU: be_f = 4'b0001 << lane;
      LSU_H, LSU_HU: be_f = lane[1] ? 4'b1100 : 4'b0011;
      LSU_W:         be_f = 4'b1111;
      default:       be_f = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] op, input logic [31:0] d);
    case (op)
      LSU_B:   wdata_f = {4{d[7:0]}};
      LSU_H:   wdata_f = {2{d[15:0]}};
      default: wdata_f = d;
    endcase
  endfunction

  function automatic logic [31:0] merge_f(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
    merge_f = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merge_f[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] ext_f(input logic [2:0] op, input logic [1:0] lane,
                                        input logic [31:0] word);
    logic [31:0] sh;
    logic [15:0] h;
    sh = word >> {lane, 3'b000};
    h  = lane[1] ? word[31:16] : word[15:0];
    case (op)
      LSU_B:   ext_f = {{24{sh[7]}}, sh[7:0]};
      LSU_BU:  ext_f = {24'd0, sh[7:0]};
      LSU_H:   ext_f = {{16{h[15]}}, h};
      LSU_HU:  ext_f = {16'd0, h};
      LSU_W:   ext_f = word;
      default: ext_f = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle between the pipeline (master) and the load-store unit (slave).
interface lsu_if;
  logic        i_req;
  logic        i_wren;
  logic [2:0]  i_lsu_op;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic [31:0] o_ld_data;
  logic        o_rsp_valid;
  logic        o_misaligned;

  modport master (
    output i_req, i_wren, i_lsu_op, i_addr, i_st_data,
    input  o_ld_data, o_rsp_valid, o_misaligned
  );

  modport slave (
    input  i_req, i_wren, i_lsu_op, i_addr, i_st_data,
    output o_ld_data, o_rsp_valid, o_misaligned
  );
endinterface

// File: rtl/lsu_dmem.sv
// Single-port data RAM with per-byte write enables and a registered read port; contents are not reset.
module lsu_dmem #(
  parameter int DEPTH_W = 512,
  parameter int AW      = $clog2(DEPTH_W)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_W];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < 4; i++) begin
          if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/lsu.sv
// Load-store unit: address decode, byte-lane stores to DMEM and LED/HEX registers,
// one-cycle pipelined load response with lane select and sign/zero extension.
module lsu
  import lsu_pkg::*;
#(
  parameter int          DMEM_DEPTH_W = 512,
  parameter logic [31:0] DMEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] IO_BASE      = 32'h1000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lsu_if.slave        bus,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex
);
  localparam int          DMEM_AW    = $clog2(DMEM_DEPTH_W);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_DEPTH_W) << 2;
  localparam logic [31:0] FULL_LEDR  = IO_BASE + ADDR_LEDR;
  localparam logic [31:0] FULL_LEDG  = IO_BASE + ADDR_LEDG;
  localparam logic [31:0] FULL_HEX   = IO_BASE + ADDR_HEX;
  localparam logic [31:0] FULL_SW    = IO_BASE + ADDR_SW;

  logic [31:0] w_dmem_off;
  region_e     w_region;
  logic        w_op_ok;
  logic        w_misal;
  logic        w_hit;
  logic        w_store;
  logic        w_load;
  logic        w_dmem_en;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_io_rd;
  logic [31:0] w_dmem_rdata;
  logic [31:0] w_rsp_word;

  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_hex;
  logic        r_rsp_valid;
  logic        r_misaligned;
  logic        r_ld_ok;
  logic        r_from_dmem;
  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_io_word;

  assign w_dmem_off = bus.i_addr - DMEM_BASE;

  // Region decode on the full word address
  always_comb begin
    w_region = REG_NONE;
    if (w_dmem_off < DMEM_BYTES) w_region = REG_DMEM;
    else if (bus.i_addr[31:2] == FULL_LEDR[31:2]) w_region = REG_LEDR;
    else if (bus.i_addr[31:2] == FULL_LEDG[31:2]) w_region = REG_LEDG;
    else if (bus.i_addr[31:2] == FULL_HEX[31:2])  w_region = REG_HEX;
    else if (bus.i_addr[31:2] == FULL_SW[31:2])   w_region = REG_SW;
    else w_region = REG_NONE;
  end

  // Op legality and alignment; unsigned ops are load-only
  always_comb begin
    w_op_ok = 1'b0;
    w_misal = 1'b0;
    case (bus.i_lsu_op)
      LSU_B:   w_op_ok = 1'b1;
      LSU_H:   begin w_op_ok = 1'b1;         w_misal = bus.i_addr[0];               end
      LSU_W:   begin w_op_ok = 1'b1;         w_misal = |bus.i_addr[1:0];            end
      LSU_BU:  w_op_ok = ~bus.i_wren;
      LSU_HU:  begin w_op_ok = ~bus.i_wren;  w_misal = ~bus.i_wren & bus.i_addr[0]; end
      default: begin w_op_ok = 1'b0;         w_misal = 1'b0;                        end
    endcase
  end

  assign w_hit     = w_op_ok & ~w_misal & (w_region != REG_NONE);
  assign w_store   = bus.i_req & bus.i_wren & w_hit;
  assign w_load    = bus.i_req & ~bus.i_wren & w_hit;
  assign w_dmem_en = (w_store | w_load) & (w_region == REG_DMEM);
  assign w_be      = be_f(bus.i_lsu_op, bus.i_addr[1:0]);
  assign w_wdata   = wdata_f(bus.i_lsu_op, bus.i_st_data);

  // Word returned by the I/O side, captured at the accepting edge
  always_comb begin
    case (w_region)
      REG_LEDR: w_io_rd = r_ledr;
      REG_LEDG: w_io_rd = r_ledg;
      REG_HEX:  w_io_rd = r_hex;
      REG_SW:   w_io_rd = i_io_sw;
      default:  w_io_rd = 32'd0;
    endcase
  end

  lsu_dmem #(.DEPTH_W(DMEM_DEPTH_W)) u_dmem (
    .i_clk   (i_clk),
    .i_en    (w_dmem_en),
    .i_we    (bus.i_wren),
    .i_be    (w_be),
    .i_addr  (w_dmem_off[DMEM_AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_dmem_rdata)
  );

  // Writable I/O registers; the switch register is read-only so it has no write path
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ledr <= 32'd0;
      r_ledg <= 32'd0;
      r_hex  <= 32'd0;
    end else if (w_store) begin
      case (w_region)
        REG_LEDR: r_ledr <= merge_f(r_ledr, w_wdata, w_be);
        REG_LEDG: r_ledg <= merge_f(r_ledg, w_wdata, w_be);
        REG_HEX:  r_hex  <= merge_f(r_hex,  w_wdata, w_be);
        default:  ;
      endcase
    end
  end

  // Response pipeline stage
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rsp_valid  <= 1'b0;
      r_misaligned <= 1'b0;
      r_ld_ok      <= 1'b0;
      r_from_dmem  <= 1'b0;
      r_op         <= 3'd0;
      r_lane       <= 2'd0;
      r_io_word    <= 32'd0;
    end else begin
      r_rsp_valid  <= bus.i_req;
      r_misaligned <= bus.i_req & w_misal;
      r_ld_ok      <= w_load;
      r_from_dmem  <= (w_region == REG_DMEM);
      r_op         <= bus.i_lsu_op;
      r_lane       <= bus.i_addr[1:0];
      r_io_word    <= w_io_rd;
    end
  end

  assign w_rsp_word       = r_from_dmem ? w_dmem_rdata : r_io_word;
  assign bus.o_ld_data    = r_ld_ok ? ext_f(r_op, r_lane, w_rsp_word) : 32'd0;
  assign bus.o_rsp_valid  = r_rsp_valid;
  assign bus.o_misaligned = r_misaligned;
  assign o_io_ledr        = r_ledr;
  assign o_io_ledg        = r_ledg;
  assign o_io_hex         = r_hex;
endmodule

// File: tb/tb_lsu.sv
// Directed plus random bench for lsu against a byte-addressed reference model.
module tb_lsu;
  logic        clk;
  logic        rst_n;
  logic [31:0] sw;
  logic [31:0] ledr;
  logic [31:0] ledg;
  logic [31:0] hex;

  int n_tests;
  int n_fail;

  logic [7:0]  m_mem [0:2047];
  logic [31:0] m_ledr;
  logic [31:0] m_ledg;
  logic [31:0] m_hex;

  lsu_if bus ();

  lsu dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .bus       (bus),
    .i_io_sw   (sw),
    .o_io_ledr (ledr),
    .o_io_ledg (ledg),
    .o_io_hex  (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: byte-addressed memory and I/O words, updated per request
  task automatic model(input logic wren, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] ld, output logic mis);
    int size;
    int sh;
    logic [31:0] io;
    ld  = 32'd0;
    mis = 1'b0;
    case (op[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      2'b10:   size = 4;
      default: size = 0;
    endcase
    if (size == 0 || (op[2] && (size == 4 || wren))) return;
    if ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00)) begin
      mis = 1'b1;
      return;
    end
    sh = 8 * int'(a[1:0]);
    if (a < 32'h800) begin
      for (int k = 0; k < size; k++) begin
        if (wren) m_mem[a + 32'(k)] = d[8*k +: 8];
        else ld = ld | (32'(m_mem[a + 32'(k)]) << (8*k));
      end
    end else if (a[31:2] == 30'h0400_0000 || a[31:2] == 30'h0400_0400 ||
                 a[31:2] == 30'h0400_0800 || a[31:2] == 30'h0400_4000) begin
      if (a[31:2] == 30'h0400_0000) io = m_ledr;
      else if (a[31:2] == 30'h0400_0400) io = m_ledg;
      else if (a[31:2] == 30'h0400_0800) io = m_hex;
      else io = sw;
      if (wren) begin
        for (int k = 0; k < size; k++) io[sh + 8*k +: 8] = d[8*k +: 8];
        if (a[31:2] == 30'h0400_0000) m_ledr = io;
        else if (a[31:2] == 30'h0400_0400) m_ledg = io;
        else if (a[31:2] == 30'h0400_0800) m_hex = io;
      end else begin
        ld = io >> sh;
      end
    end else begin
      return;
    end
    if (!wren && size < 4) begin
      ld = ld & ((32'd1 << (8*size)) - 32'd1);
      if (!op[2] && ld[8*size-1]) ld = ld | ~((32'd1 << (8*size)) - 32'd1);
    end
  endtask

  // One clock: drive at negedge, check the response just after the next posedge
  task automatic step(input logic req, input logic wren, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_ld;
    logic        exp_mis;
    @(negedge clk);
    bus.i_req     = req;
    bus.i_wren    = wren;
    bus.i_lsu_op  = op;
    bus.i_addr    = addr;
    bus.i_st_data = data;
    exp_ld  = 32'd0;
    exp_mis = 1'b0;
    if (req) model(wren, op, addr, data, exp_ld, exp_mis);
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(req));
    if (req) begin
      chk("misaligned", 32'(bus.o_misaligned), 32'(exp_mis));
      chk("ld_data", bus.o_ld_data, exp_ld);
    end
    chk("ledr", ledr, m_ledr);
    chk("ledg", ledg, m_ledg);
    chk("hex", hex, m_hex);
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    logic [2:0]  op;
    n_tests = 0;
    n_fail  = 0;
    m_ledr  = 32'd0;
    m_ledg  = 32'd0;
    m_hex   = 32'd0;
    sw      = 32'd0;
    rst_n   = 1'b0;
    bus.i_req = 1'b0; bus.i_wren = 1'b0; bus.i_lsu_op = 3'd0;
    bus.i_addr = 32'd0; bus.i_st_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("reset_misaligned", 32'(bus.o_misaligned), 32'd0);
    chk("reset_ld_data", bus.o_ld_data, 32'd0);
    chk("reset_ledr", ledr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents for the DMEM windows used below
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 3'b010, 32'(4*i), 32'd0);
    step(1'b1, 1'b1, 3'b010, 32'h7F8, 32'd0);
    step(1'b1, 1'b1, 3'b010, 32'h7FC, 32'd0);

    // Word path and byte extension
    step(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
    chk("lw_deadbeef", bus.o_ld_data, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 3'b010, 32'h10, 32'd0);
    step(1'b1, 1'b1, 3'b000, 32'h13, 32'h0000_0080);
    step(1'b1, 1'b0, 3'b000, 32'h13, 32'd0);
    chk("lb_sext", bus.o_ld_data, 32'hFFFF_FF80);
    step(1'b1, 1'b0, 3'b100, 32'h13, 32'd0);
    chk("lbu_zext", bus.o_ld_data, 32'h0000_0080);
    step(1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
    chk("lw_after_sb", bus.o_ld_data, 32'h8000_0000);

    // Misaligned accesses leave memory untouched
    step(1'b1, 1'b1, 3'b010, 32'h20, 32'h1122_3344);
    step(1'b1, 1'b0, 3'b001, 32'h21, 32'd0);
    chk("lh_misaligned", 32'(bus.o_misaligned), 32'd1);
    step(1'b1, 1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF);
    chk("sw_misaligned", 32'(bus.o_misaligned), 32'd1);
    step(1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
    chk("misalign_no_write", bus.o_ld_data, 32'h1122_3344);

    // I/O registers and read-only switches
    step(1'b1, 1'b1, 3'b001, 32'h1000_0002, 32'h0000_1234);
    chk("ledr_sh", ledr, 32'h1234_0000);
    sw = 32'h0000_00A5;
    step(1'b1, 1'b1, 3'b010, 32'h1001_0000, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 3'b010, 32'h1001_0000, 32'd0);
    chk("sw_read", bus.o_ld_data, 32'h0000_00A5);

    // Back-to-back requests
    step(1'b1, 1'b1, 3'b010, 32'h4, 32'hCAFE_F00D);
    step(1'b1, 1'b0, 3'b010, 32'h4, 32'd0);
    chk("b2b_load", bus.o_ld_data, 32'hCAFE_F00D);
    step(1'b1, 1'b0, 3'b010, 32'h8, 32'd0);
    step(1'b0, 1'b0, 3'b010, 32'h8, 32'd0);

    // Random traffic over DMEM, the DMEM top boundary, I/O and unmapped space
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = 32'h7F8 + 32'($urandom_range(0, 15));
        3:       a = 32'h1000_0000 + 32'($urandom_range(0, 2)) * 32'h1000 + 32'($urandom_range(0, 3));
        4:       a = 32'h1001_0000 + 32'($urandom_range(0, 3));
        default: a = 32'h2000_0000 | 32'($urandom_range(0, 255));
      endcase
      w  = 1'($urandom_range(0, 1));
      op = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      sw = $urandom;
      step(1'($urandom_range(0, 9) != 0), w, op, a, $urandom);
    end

    // Reset while a load response is on the bus
    step(1'b1, 1'b1, 3'b010, 32'h1000_1000, 32'h5A5A_5A5A);
    step(1'b1, 1'b1, 3'b010, 32'h30, 32'h0BAD_CAFE);
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_wren = 1'b0; bus.i_lsu_op = 3'b010; bus.i_addr = 32'h30;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(bus.o_rsp_valid), 32'd1);
    bus.i_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("mid_reset_ld_data", bus.o_ld_data, 32'd0);
    chk("mid_reset_ledr", ledr, 32'd0);
    chk("mid_reset_ledg", ledg, 32'd0);
    m_ledr = 32'd0;
    m_ledg = 32'd0;
    m_hex  = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 3'b010, 32'h30, 32'd0);
    step(1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
    chk("dmem_survives_reset", bus.o_ld_data, 32'h0BAD_CAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load-store unit directly downstream of the ALU in the milestone-2 RV32I core.
- Takes the ALU result as the effective address, rs2 as store data, and funct3 as the access type.
- Performs byte/half/word accesses to a byte-enabled data memory and memory-mapped I/O registers (LEDs, 7-seg, switches).
- Returns sign/zero-extended load data with a fixed one-cycle latency, pipelined so a new request is accepted every cycle.

Parameters:
- DMEM_DEPTH_W, 512, data memory depth in 32-bit words (2 KiB); power of two.
- DMEM_BASE, 32'h0000_0000, data memory base address.
- IO_BASE, 32'h1000_0000, I/O region base address.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous reset, active low.
- i_req  in  1  request valid this cycle.
- i_wren  in  1  1 = store, 0 = load.
- i_lsu_op  in  3  RV32I funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- i_addr  in  32  effective address (ALU o_alu_data).
- i_st_data  in  32  store data (rs2).
- i_io_sw  in  32  switch inputs.
- o_ld_data  out  32  extended load data, valid with o_rsp_valid.
- o_rsp_valid  out  1  response for the request accepted on the previous edge.
- o_misaligned  out  1  misaligned flag, qualified by o_rsp_valid.
- o_io_ledr  out  32  red LED register.
- o_io_ledg  out  32  green LED register.
- o_io_hex  out  32  four packed 7-seg bytes (hex0 = bits [7:0]).

Behaviour:
- Reset (async, i_reset=0): o_rsp_valid=0, o_misaligned=0, o_ld_data=0, o_io_ledr/ledg/hex=0. DMEM contents are not reset. The in-flight response is dropped; deasserting reset mid-operation yields no spurious o_rsp_valid.
- Acceptance: any cycle with i_req=1. No backpressure; always ready.
- Response: o_rsp_valid=1 exactly one cycle after every accepted request, loads and stores alike, otherwise 0. No request gives no response next cycle.
- Address map:
  - DMEM: DMEM_BASE .. DMEM_BASE+4*DMEM_DEPTH_W-1.
  - LEDR: IO_BASE+0x0000.
  - LEDG: IO_BASE+0x1000.
  - HEX: IO_BASE+0x2000.
  - SW: IO_BASE+0x1_0000, read-only.
  - Match is on full word address (addr[31:2]).
- Alignment:
  - Half access requires addr[0]=0; word access requires addr[1:0]=0.
  - A violation sets o_misaligned=1 with the response; no state is written; o_ld_data=0.
- Store byte lanes:
  - SB writes lane addr[1:0] with st_data[7:0].
  - SH writes lanes {addr[1],0}+{0,1} with st_data[15:0].
  - SW writes all 4 lanes.
  - Applies identically to DMEM and to LEDR/LEDG/HEX. Written at the accepting edge.
- Loads:
  - Word read at the accepting edge (DMEM synchronous read, SW sampled).
  - Lane select and extension are done in the response cycle using registered addr[1:0] and op.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Reading LEDR/LEDG/HEX returns the current register value.
- Unmapped address: store ignored; load returns 0; o_misaligned=0.
- Store to SW: ignored.
- Illegal op (011, 110, 111): treated as unmapped (no write, data 0).
- Store at edge N followed by load of the same address at edge N+1 returns the new data.
- A store-then-load accepted in the same request is impossible (single port).
- o_ld_data is 0 for store responses.

Decomposition:
- Package lsu_pkg:
  - funct3 enum lsu_op_e (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - Address constants ADDR_LEDR, ADDR_LEDG, ADDR_HEX, ADDR_SW.
  - Region-decode enum region_e (REG_DMEM, REG_LEDR, REG_LEDG, REG_HEX, REG_SW, REG_NONE).
- Sub-module lsu_dmem: single-port, 4-byte-enable, synchronous-read RAM (params DEPTH_W). Holds no reset.
- Top level: decode, byte-enable generation, I/O registers, response pipeline register, load extension.

Test Plan:
- Word path: SW 0xDEADBEEF @0x10, then LW @0x10 -> next cycle o_rsp_valid=1, o_ld_data=0xDEADBEEF, o_misaligned=0.
- Byte extend: SB 0x80 @0x13 over 0, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
- Misalign: LH @0x21 and SW @0x22 -> o_misaligned=1, o_ld_data=0, DMEM word @0x20 unchanged on readback.
- I/O: SH 0x1234 @0x10000002 -> o_io_ledr=0x12340000. i_io_sw=0xA5 then LW @0x10010000 -> 0x000000A5. SW to 0x10010000 has no effect.
- Back-to-back: requests every cycle (SW @0x4, LW @0x4, LW @0x8) -> three consecutive o_rsp_valid pulses; the second returns the stored value.
- Reset mid-op: assert i_reset low on the cycle after a load is accepted -> o_rsp_valid and LEDs go 0 immediately; DMEM data survives a post-reset readback.
